// File: rtl/if_stage_pkg.sv
// Shared widths, reset vector and fetch-buffer entry layout for the IF stage.
// No logic; imported by the interface, FIFO and top.
package if_stage_pkg;

  localparam int IF_TO_IPD_BUS_WD = 96;
  localparam int ID_TO_IF_BUS_WD  = 33;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ibuf_entry_t;

  // Static not-taken prediction: the next sequential word.
  function automatic logic [31:0] pred_next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// IF stage bus bundle: redirect input, instruction SRAM port and IPD handshake.
// master = fetch stage side, slave = SRAM / ID / IPD environment side.
interface if_stage_if;
  import if_stage_pkg::*;

  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus;
  logic                        inst_sram_en;
  logic [31:0]                 inst_sram_addr;
  logic [31:0]                 inst_sram_rdata;
  logic                        IPD_allow_in;
  logic                        IF_to_IPD_valid;
  logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus;

  modport master (
    input  ID_to_IF_bus,
    input  inst_sram_rdata,
    input  IPD_allow_in,
    output inst_sram_en,
    output inst_sram_addr,
    output IF_to_IPD_valid,
    output IF_to_IPD_bus
  );

  modport slave (
    output ID_to_IF_bus,
    output inst_sram_rdata,
    output IPD_allow_in,
    input  inst_sram_en,
    input  inst_sram_addr,
    input  IF_to_IPD_valid,
    input  IF_to_IPD_bus
  );

endinterface

// File: rtl/if_inst_fifo.sv
// Fetch buffer: circular FIFO, push/pop in the same cycle, flush clears it.
// Head is registered storage (no bypass); caller guarantees no push when full.
module if_inst_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_dat;
        tail_d        = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign head_dat = mem_q[head_q];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, one SRAM read per cycle, buffered hand-off to IPD.
// Issue-to-valid 2 cycles; stops issuing when buffer plus in-flight read would overflow.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = if_stage_pkg::RESET_PC,
  parameter int          IBUF_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  if_stage_if.master   bus_if
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;

  logic          br_cancel;
  logic [31:0]   redirect_addr;
  logic [31:0]   issue_addr;
  logic          issue;
  logic          push;
  logic          pop;
  logic          out_vld;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] fifo_count;
  ibuf_entry_t   push_entry;
  ibuf_entry_t   head_entry;

  if_inst_fifo #(
    .DEPTH (IBUF_DEPTH),
    .WIDTH ($bits(ibuf_entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .flush    (br_cancel),
    .count    (fifo_count),
    .head_dat (head_entry)
  );

  always_comb begin
    br_cancel     = bus_if.ID_to_IF_bus[32];
    redirect_addr = bus_if.ID_to_IF_bus[31:0] & ~32'h3;

    out_vld = (fifo_count != '0) & ~br_cancel & ~reset;
    pop     = out_vld & bus_if.IPD_allow_in;

    // A response landing during a redirect belongs to the wrong path.
    push            = inflight_q & ~br_cancel;
    push_entry.pc   = inflight_pc_q;
    push_entry.inst = bus_if.inst_sram_rdata;

    // Reserve a slot for every outstanding read so the push can never be refused.
    occupancy  = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
    issue      = br_cancel | (occupancy < OW'(IBUF_DEPTH));
    issue_addr = br_cancel ? redirect_addr : fetch_pc_q;

    fetch_pc_d    = issue ? issue_addr + 32'd4 : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? issue_addr : inflight_pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign bus_if.inst_sram_en    = issue & ~reset;
  assign bus_if.inst_sram_addr  = reset ? RESET_PC : issue_addr;
  assign bus_if.IF_to_IPD_valid = out_vld;
  assign bus_if.IF_to_IPD_bus   = reset ? '0
                                : {pred_next_pc(head_entry.pc), head_entry.pc, head_entry.inst};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free-run, stall, redirects, wrap and mid-stream reset.
module tb_if_stage;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  if_stage_if sif ();

  if_stage #(
    .RESET_PC   (32'h1c00_0000),
    .IBUF_DEPTH (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_a5a5;
  endfunction

  // Synchronous SRAM: data for the address presented in the previous cycle.
  always @(posedge clk) begin
    if (sif.inst_sram_en) sif.inst_sram_rdata <= inst_of(sif.inst_sram_addr);
    else                  sif.inst_sram_rdata <= 32'hdead_beef;
  end

  function automatic logic [95:0] exp_bus(input logic [31:0] pc);
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    return {nxt, pc, inst_of(pc)};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one cycle, drive inputs for the new cycle, let combinational outputs settle.
  task automatic step(input logic rst, input logic allow, input logic [32:0] id);
    @(posedge clk);
    #1;
    reset            = rst;
    sif.IPD_allow_in = allow;
    sif.ID_to_IF_bus = id;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc);
    chk({tag, "_vld"}, 96'(sif.IF_to_IPD_valid), 96'(1'b1));
    chk({tag, "_bus"}, sif.IF_to_IPD_bus, exp_bus(pc));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_vld"}, 96'(sif.IF_to_IPD_valid), 96'(1'b0));
  endtask

  task automatic expect_addr(input string tag, input logic en, input logic [31:0] addr);
    chk({tag, "_en"}, 96'(sif.inst_sram_en), 96'(en));
    if (en) chk({tag, "_addr"}, 96'(sif.inst_sram_addr), 96'(addr));
  endtask

  initial begin
    reset            = 1'b1;
    sif.IPD_allow_in = 1'b1;
    sif.ID_to_IF_bus = '0;

    // Outputs while held in reset.
    step(1'b1, 1'b1, 33'd0);
    chk("rst_en",   96'(sif.inst_sram_en),    96'(1'b0));
    chk("rst_addr", 96'(sif.inst_sram_addr),  96'(32'h1c00_0000));
    chk("rst_vld",  96'(sif.IF_to_IPD_valid), 96'(1'b0));
    chk("rst_bus",  sif.IF_to_IPD_bus,        96'd0);

    // Free run: cycle 0 and 1 issue, first valid in cycle 2.
    step(1'b0, 1'b1, 33'd0);
    expect_idle("c0");
    expect_addr("c0", 1'b1, 32'h1c00_0000);
    step(1'b0, 1'b1, 33'd0);
    expect_idle("c1");
    expect_addr("c1", 1'b1, 32'h1c00_0004);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 33'd0);
      expect_out($sformatf("run%0d", i), 32'h1c00_0000 + 32'(4 * i));
    end

    // Stall five cycles: head 0x1c000010 held, issue stops once buffer is full.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 33'd0);
      expect_out($sformatf("stall%0d", i), 32'h1c00_0010);
      expect_addr($sformatf("stall%0d", i), 1'b0, 32'h0);
    end

    // Release: both buffered entries drain in order, fetch resumes at 0x1c000018.
    step(1'b0, 1'b1, 33'd0);
    expect_out("rel0", 32'h1c00_0010);
    expect_addr("rel0", 1'b1, 32'h1c00_0018);
    step(1'b0, 1'b1, 33'd0);
    expect_out("rel1", 32'h1c00_0014);

    // Redirect with an entry buffered and a read in flight.
    step(1'b0, 1'b1, {1'b1, 32'h1c00_0100});
    expect_idle("redir_now");
    expect_addr("redir_now", 1'b1, 32'h1c00_0100);
    step(1'b0, 1'b1, 33'd0);
    expect_idle("redir_p1");
    expect_addr("redir_p1", 1'b1, 32'h1c00_0104);
    step(1'b0, 1'b1, 33'd0);
    expect_out("redir_p2", 32'h1c00_0100);
    step(1'b0, 1'b1, 33'd0);
    expect_out("redir_p3", 32'h1c00_0104);

    // Unaligned redirect target is word aligned.
    step(1'b0, 1'b1, {1'b1, 32'h1c00_0103});
    expect_addr("unal", 1'b1, 32'h1c00_0100);
    step(1'b0, 1'b1, 33'd0);
    expect_idle("unal_p1");
    step(1'b0, 1'b1, 33'd0);
    expect_out("unal_p2", 32'h1c00_0100);

    // Back-to-back redirects: the second wins, 0x200 never delivered.
    step(1'b0, 1'b1, {1'b1, 32'h0000_0200});
    expect_idle("bb0");
    expect_addr("bb0", 1'b1, 32'h0000_0200);
    step(1'b0, 1'b1, {1'b1, 32'h0000_0300});
    expect_idle("bb1");
    expect_addr("bb1", 1'b1, 32'h0000_0300);
    step(1'b0, 1'b1, 33'd0);
    expect_idle("bb2");
    step(1'b0, 1'b1, 33'd0);
    expect_out("bb3", 32'h0000_0300);
    step(1'b0, 1'b1, 33'd0);
    expect_out("bb4", 32'h0000_0304);

    // Address wrap at the top of the 32-bit space.
    step(1'b0, 1'b1, {1'b1, 32'hffff_fffc});
    expect_addr("wrap0", 1'b1, 32'hffff_fffc);
    step(1'b0, 1'b1, 33'd0);
    expect_addr("wrap1", 1'b1, 32'h0000_0000);
    step(1'b0, 1'b1, 33'd0);
    expect_out("wrap2", 32'hffff_fffc);
    step(1'b0, 1'b1, 33'd0);
    expect_out("wrap3", 32'h0000_0000);

    // One-cycle reset mid-stream restarts at the reset vector.
    step(1'b1, 1'b1, 33'd0);
    chk("mrst_en",  96'(sif.inst_sram_en),    96'(1'b0));
    chk("mrst_vld", 96'(sif.IF_to_IPD_valid), 96'(1'b0));
    chk("mrst_bus", sif.IF_to_IPD_bus,        96'd0);
    step(1'b0, 1'b1, 33'd0);
    expect_idle("mrst_c0");
    expect_addr("mrst_c0", 1'b1, 32'h1c00_0000);
    step(1'b0, 1'b1, 33'd0);
    expect_idle("mrst_c1");
    step(1'b0, 1'b1, 33'd0);
    expect_out("mrst_c2", 32'h1c00_0000);
    step(1'b0, 1'b1, 33'd0);
    expect_out("mrst_c3", 32'h1c00_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
